// File: rtl/nios_system_nios2_cpu_debug_ocimem_ctrl.sv
// Debug monitor RAM access controller: turns the debug-slave ocimem pulses
// into single-word Avalon-MM reads/writes and reports data, ready and error.
module nios_system_nios2_cpu_debug_ocimem_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [ADDR_W+1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_waitrequest
);

    typedef enum logic [1:0] {IDLE, RD, WR} state_t;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

    state_t            state, next_state;
    logic [ADDR_W-1:0] mon_areg, next_areg;
    logic [31:0]       next_dreg;
    logic              next_ready, next_error, next_read, next_write;
    logic [15:0]       wcnt, next_wcnt;
    logic              rd_inc, next_inc;
    logic              any_take;
    logic [15:0]       wcnt_inc;

    // jdo bits outside the command fields carry nothing for this block
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

    assign any_take      = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign wcnt_inc      = wcnt + 16'd1;
    assign avm_address   = {mon_areg, 2'b00};
    assign avm_writedata = MonDReg;

    // Next-state and next-register logic; error set is evaluated after the
    // clear so that a fresh error in the clearing cycle leaves the flag at 1.
    // The stall counter is compared after its increment, so the request is
    // dropped in the cycle the count reaches TIMEOUT.
    always_comb begin
        next_state = state;
        next_areg  = mon_areg;
        next_dreg  = MonDReg;
        next_ready = monitor_ready;
        next_error = monitor_error;
        next_read  = avm_read;
        next_write = avm_write;
        next_wcnt  = wcnt;
        next_inc   = rd_inc;
        unique case (state)
            IDLE: begin
                if (take_action_ocimem_a) begin
                    next_areg = jdo[17+ADDR_W-1:17];
                    if (jdo[35]) next_error = 1'b0;
                    if (jdo[34]) begin
                        next_state = RD;
                        next_read  = 1'b1;
                        next_ready = 1'b0;
                        next_wcnt  = 16'd0;
                        next_inc   = 1'b0;
                    end
                    if (take_action_ocimem_b || take_no_action_ocimem_a) next_error = 1'b1;
                end else if (take_action_ocimem_b) begin
                    next_dreg  = jdo[34:3];
                    next_state = WR;
                    next_write = 1'b1;
                    next_ready = 1'b0;
                    next_wcnt  = 16'd0;
                    if (take_no_action_ocimem_a) next_error = 1'b1;
                end else if (take_no_action_ocimem_a) begin
                    next_state = RD;
                    next_read  = 1'b1;
                    next_ready = 1'b0;
                    next_wcnt  = 16'd0;
                    next_inc   = 1'b1;
                end
            end
            RD: begin
                if (!avm_waitrequest) begin
                    next_dreg  = avm_readdata;
                    next_read  = 1'b0;
                    if (rd_inc) next_areg = mon_areg + 1'b1;
                    next_state = IDLE;
                    next_ready = 1'b1;
                end else begin
                    next_wcnt = wcnt_inc;
                    if (wcnt_inc == TIMEOUT_W) begin
                        next_read  = 1'b0;
                        next_error = 1'b1;
                        next_state = IDLE;
                        next_ready = 1'b1;
                    end
                end
                if (any_take) next_error = 1'b1;
            end
            WR: begin
                if (!avm_waitrequest) begin
                    next_write = 1'b0;
                    next_areg  = mon_areg + 1'b1;
                    next_state = IDLE;
                    next_ready = 1'b1;
                end else begin
                    next_wcnt = wcnt_inc;
                    if (wcnt_inc == TIMEOUT_W) begin
                        next_write = 1'b0;
                        next_error = 1'b1;
                        next_state = IDLE;
                        next_ready = 1'b1;
                    end
                end
                if (any_take) next_error = 1'b1;
            end
            default: begin
                next_state = IDLE;
                next_read  = 1'b0;
                next_write = 1'b0;
                next_ready = 1'b1;
            end
        endcase
    end

    // State and register update; reset drops any in-flight request at once
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            mon_areg      <= '0;
            MonDReg       <= '0;
            monitor_ready <= 1'b1;
            monitor_error <= 1'b0;
            avm_read      <= 1'b0;
            avm_write     <= 1'b0;
            wcnt          <= '0;
            rd_inc        <= 1'b0;
        end else begin
            state         <= next_state;
            mon_areg      <= next_areg;
            MonDReg       <= next_dreg;
            monitor_ready <= next_ready;
            monitor_error <= next_error;
            avm_read      <= next_read;
            avm_write     <= next_write;
            wcnt          <= next_wcnt;
            rd_inc        <= next_inc;
        end
    end

endmodule

// File: tb/tb_nios_system_nios2_cpu_debug_ocimem_ctrl.sv
// Scoreboard bench for the ocimem controller: expected bus transfers and
// completions are queued by the stimulus and popped by a monitor.
module tb_nios_system_nios2_cpu_debug_ocimem_ctrl;

    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] data;
    } bus_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } done_t;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_no_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;
    logic [9:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    int    checks = 0;
    int    fails  = 0;
    int    stall  = 0;
    int    scnt   = 0;
    bus_t  bus_q[$];
    done_t done_q[$];
    logic  prev_ready;

    nios_system_nios2_cpu_debug_ocimem_ctrl #(.ADDR_W(8), .TIMEOUT(255)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error),
        .avm_address             (avm_address),
        .avm_read                (avm_read),
        .avm_write               (avm_write),
        .avm_writedata           (avm_writedata),
        .avm_readdata            (avm_readdata),
        .avm_waitrequest         (avm_waitrequest)
    );

    // Free-running system clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Overall time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, required to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [37:0] jdo_a(input logic clr, input logic rd, input logic [7:0] addr);
        logic [37:0] j;
        j        = '0;
        j[35]    = clr;
        j[34]    = rd;
        j[24:17] = addr;
        return j;
    endfunction

    function automatic logic [37:0] jdo_b(input logic [31:0] data);
        logic [37:0] j;
        j       = '0;
        j[34:3] = data;
        return j;
    endfunction

    task automatic expect_bus(input logic wr, input logic [9:0] addr, input logic [31:0] data);
        bus_t e;
        e.wr = wr; e.addr = addr; e.data = data;
        bus_q.push_back(e);
    endtask

    task automatic expect_done(input logic [31:0] data, input logic err);
        done_t e;
        e.data = data; e.err = err;
        done_q.push_back(e);
    endtask

    // One-cycle pulse on the selected take_* lines with the given jdo word
    task automatic apply_stimulus(input logic a, input logic n, input logic b, input logic [37:0] j);
        @(posedge clk); #1;
        jdo                     = j;
        take_action_ocimem_a    = a;
        take_no_action_ocimem_a = n;
        take_action_ocimem_b    = b;
        @(posedge clk); #1;
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (monitor_ready !== 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check_output("ready_back", 64'(monitor_ready), 64'd1);
    endtask

    // Slave model: stalls each request for 'stall' cycles, then accepts
    initial begin
        avm_waitrequest = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (avm_read || avm_write) begin
                if (scnt < stall) begin
                    avm_waitrequest = 1'b1;
                    scnt++;
                end else begin
                    avm_waitrequest = 1'b0;
                end
            end else begin
                scnt = 0;
                avm_waitrequest = 1'b0;
            end
        end
    end

    // Monitor: accepted bus transfers and ready rising edges against queues
    initial begin
        bus_t  eb;
        done_t ed;
        prev_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if ((avm_read || avm_write) && !avm_waitrequest) begin
                    if (bus_q.size() == 0) begin
                        checks++; fails++;
                        $display("[TB] FAIL bus_unexpected: got wr=%0b addr=%0h, expected no transfer", avm_write, avm_address);
                    end else begin
                        eb = bus_q.pop_front();
                        check_output("bus_write", 64'(avm_write), 64'(eb.wr));
                        check_output("bus_read", 64'(avm_read), 64'(!eb.wr));
                        check_output("bus_addr", 64'(avm_address), 64'(eb.addr));
                        if (eb.wr) check_output("bus_wdata", 64'(avm_writedata), 64'(eb.data));
                    end
                end
                if (monitor_ready && !prev_ready) begin
                    if (done_q.size() == 0) begin
                        checks++; fails++;
                        $display("[TB] FAIL done_unexpected: got MonDReg=%0h, expected no completion", MonDReg);
                    end else begin
                        ed = done_q.pop_front();
                        check_output("done_data", 64'(MonDReg), 64'(ed.data));
                        check_output("done_error", 64'(monitor_error), 64'(ed.err));
                    end
                end
            end
            prev_ready = monitor_ready;
        end
    end

    // Directed sequence
    initial begin
        int cnt;
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        avm_readdata = '0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check_output("rst_ready", 64'(monitor_ready), 64'd1);
        check_output("rst_error", 64'(monitor_error), 64'd0);
        check_output("rst_read", 64'(avm_read), 64'd0);
        check_output("rst_write", 64'(avm_write), 64'd0);
        check_output("rst_dreg", 64'(MonDReg), 64'd0);
        check_output("rst_addr", 64'(avm_address), 64'd0);

        // Read at 0x10 with two stall cycles
        stall = 2; avm_readdata = 32'hDEADBEEF;
        expect_bus(1'b0, 10'h040, 32'h0);
        expect_done(32'hDEADBEEF, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b1, 8'h10));
        check_output("rd_busy", 64'(monitor_ready), 64'd0);
        check_output("rd_req", 64'(avm_read), 64'd1);
        wait_ready();

        // Minimum-latency auto-increment read still at 0x10
        stall = 0; avm_readdata = 32'hCAFEF00D;
        expect_bus(1'b0, 10'h040, 32'h0);
        expect_done(32'hCAFEF00D, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 38'h0);
        @(negedge clk);
        check_output("lat_req_cycle", 64'(monitor_ready), 64'd0);
        @(negedge clk);
        check_output("lat_ready_cycle", 64'(monitor_ready), 64'd1);

        // Address-only command, then write at 0xFF wrapping to 0
        apply_stimulus(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b0, 8'hFF));
        @(negedge clk);
        check_output("addr_only_ready", 64'(monitor_ready), 64'd1);
        check_output("addr_only_read", 64'(avm_read), 64'd0);
        stall = 1;
        expect_bus(1'b1, 10'h3FC, 32'h12345678);
        expect_done(32'h12345678, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, jdo_b(32'h12345678));
        wait_ready();
        stall = 0; avm_readdata = 32'h0BADF00D;
        expect_bus(1'b0, 10'h000, 32'h0);
        expect_done(32'h0BADF00D, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 38'h0);
        wait_ready();
        avm_readdata = 32'h11112222;
        expect_bus(1'b0, 10'h004, 32'h0);
        expect_done(32'h11112222, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 38'h0);
        wait_ready();

        // Permanent stall: read aborts after TIMEOUT cycles
        stall = 100000; avm_readdata = 32'h55555555;
        expect_done(32'h11112222, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b1, 8'h20));
        cnt = 0;
        @(negedge clk);
        while (avm_read === 1'b1 && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        check_output("timeout_cycles", 64'(cnt), 64'd255);
        check_output("timeout_error", 64'(monitor_error), 64'd1);
        stall = 0;
        apply_stimulus(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 1'b0, 8'h00));
        @(negedge clk);
        check_output("error_cleared", 64'(monitor_error), 64'd0);

        // Write pulse during an in-flight read is dropped
        stall = 3; avm_readdata = 32'hA5A5A5A5;
        expect_bus(1'b0, 10'h0C0, 32'h0);
        expect_done(32'hA5A5A5A5, 1'b1);
        apply_stimulus(1'b1, 1'b0, 1'b0, jdo_a(1'b0, 1'b1, 8'h30));
        apply_stimulus(1'b0, 1'b0, 1'b1, jdo_b(32'h99999999));
        wait_ready();
        repeat (4) @(negedge clk);

        // Clear collides with a dropped pulse: new error wins
        stall = 0;
        apply_stimulus(1'b1, 1'b0, 1'b1, jdo_a(1'b1, 1'b0, 8'h40));
        @(negedge clk);
        check_output("clear_vs_new_error", 64'(monitor_error), 64'd1);
        apply_stimulus(1'b1, 1'b0, 1'b0, jdo_a(1'b1, 1'b0, 8'h40));
        @(negedge clk);
        check_output("clear_alone", 64'(monitor_error), 64'd0);

        // Reset in the middle of a stalled write
        stall = 100000;
        apply_stimulus(1'b0, 1'b0, 1'b1, jdo_b(32'hFEEDFACE));
        repeat (3) @(negedge clk);
        check_output("wr_held", 64'(avm_write), 64'd1);
        check_output("wr_addr_held", 64'(avm_address), 64'h100);
        check_output("wr_data_held", 64'(avm_writedata), 64'hFEEDFACE);
        #2 reset_n = 1'b0;
        #1;
        check_output("rst_mid_write", 64'(avm_write), 64'd0);
        check_output("rst_mid_ready", 64'(monitor_ready), 64'd1);
        check_output("rst_mid_dreg", 64'(MonDReg), 64'd0);
        stall = 0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        avm_readdata = 32'h00000077;
        expect_bus(1'b0, 10'h000, 32'h0);
        expect_done(32'h00000077, 1'b0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 38'h0);
        wait_ready();

        repeat (3) @(negedge clk);
        check_output("bus_q_drained", 64'(bus_q.size()), 64'd0);
        check_output("done_q_drained", 64'(done_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/nios_system_nios2_cpu_debug_ocimem_ctrl.md
Name: nios_system_Nios2_cpu_debug_ocimem_ctrl

Overview:
- Sits directly downstream of the debug-slave wrapper, in the system-clock domain.
- Consumes its jdo word and the ocimem take_action / take_no_action pulses.
- Performs single-word reads and writes on an Avalon-MM master port into the debug monitor RAM.
- Returns MonDReg, monitor_ready and monitor_error to the debug slave for JTAG capture.

Parameters:
- ADDR_W, 8: word-address width of the monitor RAM.
- TIMEOUT, 255: max cycles an access may wait on avm_waitrequest before aborting (1..2^16-1).

Ports:
- clk  in  1  system clock, same as the debug-slave sysclk stage.
- reset_n  in  1  asynchronous active-low reset.
- jdo  in  38  JTAG data word, stable whenever any take_* pulse is high.
- take_action_ocimem_a  in  1  1-cycle pulse: set address, optional read, optional error clear.
- take_no_action_ocimem_a  in  1  1-cycle pulse: read at current address, then auto-increment.
- take_action_ocimem_b  in  1  1-cycle pulse: write data at current address, then auto-increment.
- MonDReg  out  32  last read data, or last write data.
- monitor_ready  out  1  high when idle and able to accept a command.
- monitor_error  out  1  sticky error flag.
- avm_address  out  ADDR_W+2  byte address = {MonAReg, 2'b00}.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data (= MonDReg).
- avm_readdata  in  32  read data, valid in the cycle avm_read is high and avm_waitrequest is low.
- avm_waitrequest  in  1  slave stall.

Behaviour:
- Reset (async assert, deassert sampled on clk): state IDLE; MonAReg=0, MonDReg=0, monitor_ready=1, monitor_error=0, avm_read=0, avm_write=0, timeout counter=0.
- Internal registers: MonAReg[ADDR_W-1:0]; 16-bit wait counter wcnt.
- FSM states: IDLE, RD, WR.
- IDLE, take_action_ocimem_a:
  - MonAReg <= jdo[17+ADDR_W-1:17].
  - If jdo[35]=1, monitor_error <= 0.
  - If jdo[34]=1, go to RD; otherwise stay in IDLE.
- IDLE, take_no_action_ocimem_a: go to RD at the current MonAReg.
- IDLE, take_action_ocimem_b: MonDReg <= jdo[34:3], go to WR.
- Pulse priority in the same cycle: take_action_ocimem_a > take_action_ocimem_b > take_no_action_ocimem_a. Lower-priority pulses are dropped and set monitor_error.
- Request timing:
  - On entering RD or WR, avm_read or avm_write rises on the next cycle (registered); monitor_ready=0 from that same cycle.
  - avm_address and avm_writedata are held constant while the request is asserted.
- RD: in the cycle avm_waitrequest=0:
  - MonDReg <= avm_readdata; avm_read <= 0.
  - If the entry was via take_no_action_ocimem_a, MonAReg <= MonAReg+1.
  - Go to IDLE; monitor_ready=1 on the following cycle.
- WR: in the cycle avm_waitrequest=0: avm_write <= 0, MonAReg <= MonAReg+1, go to IDLE.
- Minimum latency from pulse to monitor_ready re-asserted: 3 cycles (pulse, request, ready).
- Auto-increment wraps modulo 2^ADDR_W (all-ones to 0), no error.
- Timeout:
  - wcnt clears on RD/WR entry and increments each cycle avm_waitrequest=1.
  - When wcnt reaches TIMEOUT: request dropped, monitor_error <= 1, MonDReg and MonAReg unchanged, go to IDLE.
- Any take_* pulse while in RD or WR is ignored and sets monitor_error. The ongoing access completes normally.
- monitor_error can only be cleared by take_action_ocimem_a with jdo[35]=1. A simultaneous new error in that cycle wins, leaving the flag at 1.
- Reset mid-access: request deasserts immediately (async); no completion; all registers return to their reset values.

Test Plan:
- Reset, then idle with no pulses -> monitor_ready=1, monitor_error=0, avm_read=avm_write=0, MonDReg=0.
- take_action_ocimem_a with jdo[24:17]=8'h10, jdo[34]=1; slave waitrequest=1 for 2 cycles, readdata=32'hDEADBEEF -> avm_address=10'h040, MonDReg=32'hDEADBEEF, MonAReg stays 8'h10, ready=1 after completion.
- Set address 8'hFF, then take_action_ocimem_b with jdo[34:3]=32'h12345678 -> one write to 10'h3FC with data 32'h12345678; MonAReg wraps to 0. A following take_no_action_ocimem_a reads at 10'h000 and leaves MonAReg=1.
- Hold waitrequest=1 permanently with TIMEOUT=255, then issue a read -> avm_read drops after 255 stall cycles, monitor_error=1, MonDReg unchanged. take_action_ocimem_a with jdo[35]=1, jdo[34]=0 -> monitor_error=0.
- take_action_ocimem_b during an in-flight read -> read completes with correct data, the write is never issued, monitor_error=1.
- Assert reset_n=0 mid-write while waitrequest=1 -> avm_write=0 immediately, monitor_ready=1, MonAReg=0.
